// File: rtl/subtractor_serial_if.sv
// Handshake bundle for the bit-serial subtractor: operand load and result unload channels.
interface subtractor_serial_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             diff_valid;
    logic             diff_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start_valid, a, b, diff_ready,
        input  start_ready, diff_valid, diff, borrow_out
    );

    modport slave (
        input  start_valid, a, b, diff_ready,
        output start_ready, diff_valid, diff, borrow_out
    );
endinterface

// File: rtl/subtractor_serial.sv
// Bit-serial two's-complement subtractor: a - b, one bit per clock, LSB first,
// borrow held in a flip-flop between bit steps.
module subtractor_serial #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    subtractor_serial_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sa_next;
    logic [WIDTH-1:0] sb_next;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_next;
    logic             d;
    logic             bo_q;

    // The minuend register doubles as the result register: each step consumes
    // sa[0] and refills the vacated MSB with the new difference bit.
    always_comb begin
        d       = sa[0] ^ sb[0] ^ br;
        br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sa_next = (sa >> 1) | (WIDTH'(d) << (WIDTH - 1));
        sb_next = sb >> 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff_q <= '0;
            bo_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa_next;
                    sb  <= sb_next;
                    br  <= br_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        diff_q <= sa_next;
                        bo_q   <= br_next;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.diff_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.diff_valid  = (state == DONE);
    assign bus.diff        = diff_q;
    assign bus.borrow_out  = bo_q;
endmodule

// File: tb/tb_subtractor_serial.sv
// Bench for subtractor_serial: directed vectors, handshake corner cases, reset
// abort, and randomized back-to-back traffic on WIDTH=8 and WIDTH=1 instances.
module tb_subtractor_serial;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    subtractor_serial_if #(.WIDTH(8)) bus8 ();
    subtractor_serial_if #(.WIDTH(1)) bus1 ();

    subtractor_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    subtractor_serial #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int passed = 0;
    int total  = 0;

    function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        r = x - y;
        return {x < y, r};
    endfunction

    function automatic logic [1:0] ref1(input logic x, input logic y);
        logic r;
        r = x - y;
        return {x < y, r};
    endfunction

    task automatic start8(input logic [7:0] av, input logic [7:0] bv);
        int guard = 0;
        @(negedge clk);
        bus8.a = av;
        bus8.b = bv;
        bus8.start_valid = 1'b1;
        while (!bus8.start_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus8.start_valid = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
    endtask

    // Counts rising edges after the accepting edge until diff_valid is seen.
    task automatic wait_done8(output int edges);
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus8.diff_valid) break;
        end
    endtask

    task automatic unload8();
        @(negedge clk);
        bus8.diff_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.diff_ready = 1'b0;
    endtask

    task automatic test_reset();
        #4;
        total++;
        if (bus8.diff_valid !== 1'b0 || bus8.diff !== 8'h00 || bus8.borrow_out !== 1'b0) begin
            $display("FAIL reset_outputs: valid=%b diff=%h borrow=%b, required 0/00/0",
                     bus8.diff_valid, bus8.diff, bus8.borrow_out);
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus8.start_ready !== 1'b1 || bus1.start_ready !== 1'b1) begin
            $display("FAIL reset_ready: start_ready8=%b start_ready1=%b, required 1/1",
                     bus8.start_ready, bus1.start_ready);
        end else passed++;
    endtask

    task automatic test_directed();
        logic [7:0] ta [4] = '{8'd200, 8'd5,   8'hA5, 8'h00};
        logic [7:0] tb [4] = '{8'd55,  8'd10,  8'hA5, 8'hFF};
        logic [7:0] td [4] = '{8'd145, 8'hFB,  8'h00, 8'h01};
        logic       tbo[4] = '{1'b0,   1'b1,   1'b0,  1'b1};
        int edges;
        for (int i = 0; i < 4; i++) begin
            start8(ta[i], tb[i]);
            wait_done8(edges);
            total++;
            if (edges !== 8) $display("FAIL dir_latency[%0d]: got %0d edges, required 8", i, edges);
            else passed++;
            total++;
            if ({bus8.borrow_out, bus8.diff} !== {tbo[i], td[i]})
                $display("FAIL dir_result[%0d]: got borrow=%b diff=%h, required borrow=%b diff=%h",
                         i, bus8.borrow_out, bus8.diff, tbo[i], td[i]);
            else passed++;
            unload8();
            total++;
            if (bus8.diff_valid !== 1'b0 || bus8.start_ready !== 1'b1)
                $display("FAIL dir_unload[%0d]: valid=%b ready=%b, required 0/1",
                         i, bus8.diff_valid, bus8.start_ready);
            else passed++;
        end
    endtask

    task automatic test_stall();
        int edges;
        start8(8'd77, 8'd33);
        wait_done8(edges);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (bus8.diff_valid !== 1'b1 || bus8.diff !== 8'd44 || bus8.borrow_out !== 1'b0)
                $display("FAIL stall_hold[%0d]: valid=%b diff=%h borrow=%b, required 1/2c/0",
                         c, bus8.diff_valid, bus8.diff, bus8.borrow_out);
            else passed++;
        end
        unload8();
    endtask

    task automatic test_ignore_start();
        int edges;
        start8(8'd9, 8'd4);
        bus8.start_valid = 1'b1;
        bus8.a = 8'h00;
        bus8.b = 8'hFF;
        bus8.diff_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (bus8.start_ready !== 1'b0) $display("FAIL run_ready[%0d]: start_ready=%b, required 0", c, bus8.start_ready);
            else passed++;
        end
        bus8.start_valid = 1'b0;
        bus8.diff_ready = 1'b0;
        wait_done8(edges);
        total++;
        if (edges + 3 !== 8) $display("FAIL ign_latency: got %0d edges, required 8", edges + 3);
        else passed++;
        total++;
        if (bus8.diff !== 8'd5 || bus8.borrow_out !== 1'b0)
            $display("FAIL ign_result: diff=%h borrow=%b, required 05/0", bus8.diff, bus8.borrow_out);
        else passed++;
        unload8();
        repeat (2) @(negedge clk);
        total++;
        if (bus8.start_ready !== 1'b1 || bus8.diff_valid !== 1'b0)
            $display("FAIL ign_no_extra: ready=%b valid=%b, required 1/0", bus8.start_ready, bus8.diff_valid);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int edges;
        start8(8'd100, 8'd20);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus8.diff !== 8'h00 || bus8.borrow_out !== 1'b0 || bus8.diff_valid !== 1'b0)
            $display("FAIL mid_reset: diff=%h borrow=%b valid=%b, required 00/0/0",
                     bus8.diff, bus8.borrow_out, bus8.diff_valid);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (bus8.diff_valid !== 1'b0 || bus8.start_ready !== 1'b1)
            $display("FAIL mid_reset_idle: valid=%b ready=%b, required 0/1", bus8.diff_valid, bus8.start_ready);
        else passed++;
        start8(8'd3, 8'd1);
        wait_done8(edges);
        total++;
        if (edges !== 8 || bus8.diff !== 8'd2 || bus8.borrow_out !== 1'b0)
            $display("FAIL post_reset: edges=%0d diff=%h borrow=%b, required 8/02/0",
                     edges, bus8.diff, bus8.borrow_out);
        else passed++;
        unload8();
    endtask

    task automatic test_width1();
        logic xa [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic xb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] xe [4] = '{2'b00, 2'b01, 2'b11, 2'b00};
        int edges;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus1.a = xa[i];
            bus1.b = xb[i];
            bus1.start_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus1.start_valid = 1'b0;
            edges = 0;
            while (edges < 10) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
                if (bus1.diff_valid) break;
            end
            total++;
            if (edges !== 1 || {bus1.borrow_out, bus1.diff} !== xe[i])
                $display("FAIL w1[%0d]: edges=%0d borrow=%b diff=%b, required 1/%b/%b",
                         i, edges, bus1.borrow_out, bus1.diff, xe[i][1], xe[i][0]);
            else passed++;
            bus1.diff_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus1.diff_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 500;
        localparam int LIMIT = 30000;
        logic [8:0] q8[$];
        logic [1:0] q1[$];
        fork
            begin : drv8
                logic [7:0] av, bv;
                int guard = 0;
                for (int i = 0; i < N; i++) begin
                    av = 8'($urandom);
                    bv = 8'($urandom);
                    if (i % 7 == 0) bv = av;
                    @(negedge clk);
                    bus8.a = av;
                    bus8.b = bv;
                    bus8.start_valid = 1'b1;
                    while (!bus8.start_ready && guard < LIMIT) begin
                        @(negedge clk);
                        guard++;
                    end
                    q8.push_back(ref8(av, bv));
                end
                @(negedge clk);
                bus8.start_valid = 1'b0;
            end
            begin : chk8
                int got = 0, cyc = 0;
                logic r;
                logic [8:0] e;
                while (got < N && cyc < LIMIT) begin
                    @(negedge clk);
                    cyc++;
                    r = 1'($urandom_range(0, 2) != 0);
                    bus8.diff_ready = r;
                    if (bus8.diff_valid && r) begin
                        e = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
                        got++;
                        total++;
                        if ({bus8.borrow_out, bus8.diff} !== e)
                            $display("FAIL rand8[%0d]: got borrow=%b diff=%h, required borrow=%b diff=%h",
                                     got, bus8.borrow_out, bus8.diff, e[8], e[7:0]);
                        else passed++;
                    end
                end
                @(negedge clk);
                bus8.diff_ready = 1'b0;
                total++;
                if (got !== N) $display("FAIL rand8_count: got %0d results, required %0d", got, N);
                else passed++;
            end
            begin : drv1
                logic av, bv;
                int guard = 0;
                for (int i = 0; i < N; i++) begin
                    av = 1'($urandom);
                    bv = 1'($urandom);
                    @(negedge clk);
                    bus1.a = av;
                    bus1.b = bv;
                    bus1.start_valid = 1'b1;
                    while (!bus1.start_ready && guard < LIMIT) begin
                        @(negedge clk);
                        guard++;
                    end
                    q1.push_back(ref1(av, bv));
                end
                @(negedge clk);
                bus1.start_valid = 1'b0;
            end
            begin : chk1
                int got = 0, cyc = 0;
                logic r;
                logic [1:0] e;
                while (got < N && cyc < LIMIT) begin
                    @(negedge clk);
                    cyc++;
                    r = 1'($urandom_range(0, 2) != 0);
                    bus1.diff_ready = r;
                    if (bus1.diff_valid && r) begin
                        e = (q1.size() > 0) ? q1.pop_front() : 2'bxx;
                        got++;
                        total++;
                        if ({bus1.borrow_out, bus1.diff} !== e)
                            $display("FAIL rand1[%0d]: got borrow=%b diff=%b, required %b",
                                     got, bus1.borrow_out, bus1.diff, e);
                        else passed++;
                    end
                end
                @(negedge clk);
                bus1.diff_ready = 1'b0;
                total++;
                if (got !== N) $display("FAIL rand1_count: got %0d results, required %0d", got, N);
                else passed++;
            end
        join
        total++;
        if (q8.size() != 0 || q1.size() != 0)
            $display("FAIL rand_leftover: q8=%0d q1=%0d entries, required 0/0", q8.size(), q1.size());
        else passed++;
    endtask

    initial begin
        bus8.start_valid = 1'b0;
        bus8.diff_ready  = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus1.start_valid = 1'b0;
        bus1.diff_ready  = 1'b0;
        bus1.a = '0;
        bus1.b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_ignore_start();
        test_reset_mid_run();
        test_width1();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
